shift_ctrl: RTL and testbench

Synchronous sequencer that drives the upstream side of the team's N-bit shift register: it accepts a parallel word over a valid/ready handshake, issues a one-cycle parallel load, then generates N glitch-free shift strobes at a programmable rate. It sits between the clocked system logic and the shift register's load/shift/serial_in/parallel_in pins. All strobes are registered, so the shift register's edge-triggered inputs only ever see clean edges.

---
 rtl/shift_ctrl_pkg.sv | 20 ++
 rtl/shift_bit_timer.sv | 30 +++
 rtl/shift_ctrl.sv | 142 ++++++++++++++
 tb/tb_shift_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the shift register sequencer.
// State encoding, default divider width and the div==0 -> 1 mapping.
package shift_ctrl_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  // A zero divider would give a zero-length low phase; treat it as one cycle.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/shift_bit_timer.sv
// Loadable down-counter timing the shift-low phase; expire flags the last low cycle.
// Zero latency from count to expire; no backpressure.
module shift_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_period,
  input  logic             i_en,
  output logic             o_expire
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_period;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_expire = i_en && (r_cnt == ONE);

endmodule

// File: rtl/shift_ctrl.sv
// Shift register sequencer: accept word, 1-cycle load, N registered shift strobes every max(div,1)+1 cycles.
// start_ready only in IDLE (requests ignored while busy); optional rx capture under SHIFT_CTRL_CAPTURE_EN.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N-1:0]     tx_data,
  input  logic             fill_bit,
  input  logic [DIV_W-1:0] div,
  input  logic             sr_serial_out,
  output logic             sr_load,
  output logic             sr_shift,
  output logic             sr_serial_in,
  output logic [N-1:0]     sr_parallel_in,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     rx_data
);

  localparam int               CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_accept;
  logic             w_tmr_load;
  logic             w_tmr_expire;
  logic             r_sr_load;
  logic             r_sr_shift;
  logic             r_sr_serial_in;
  logic [N-1:0]     r_sr_parallel_in;
  logic             r_busy;
  logic             r_done;

  assign w_div_eff   = DIV_W'(eff_div(32'(div)));
  assign start_ready = (r_state == IDLE);
  assign w_accept    = start_valid && (r_state == IDLE);

  shift_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_tmr_load),
    .i_period (r_period),
    .i_en     (r_state == SHIFT_LO),
    .o_expire (w_tmr_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    case (r_state)
      IDLE:     if (start_valid) w_state_nxt = LOAD;
      LOAD: begin
        w_state_nxt = SHIFT_LO;
        w_tmr_load  = 1'b1;
      end
      SHIFT_LO: if (w_tmr_expire) w_state_nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT_LO;
          w_tmr_load  = 1'b1;
        end
      end
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr_load        <= 1'b0;
      r_sr_shift       <= 1'b0;
      r_done           <= 1'b0;
      r_busy           <= 1'b0;
      r_sr_serial_in   <= 1'b0;
      r_sr_parallel_in <= '0;
      r_period         <= '0;
      r_bit_cnt        <= '0;
    end else begin
      r_sr_load  <= (w_state_nxt == LOAD);
      r_sr_shift <= (w_state_nxt == SHIFT_HI);
      r_done     <= (w_state_nxt == DONE);
      r_busy     <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_sr_parallel_in <= tx_data;
        r_sr_serial_in   <= fill_bit;
        r_period         <= w_div_eff;
        r_bit_cnt        <= '0;
      end else begin
        if (w_state_nxt == IDLE) r_sr_serial_in <= 1'b0;
        if (r_state == SHIFT_HI) r_bit_cnt <= r_bit_cnt + CNT_ONE;
      end
    end
  end

  assign sr_load        = r_sr_load;
  assign sr_shift       = r_sr_shift;
  assign sr_serial_in   = r_sr_serial_in;
  assign sr_parallel_in = r_sr_parallel_in;
  assign busy           = r_busy;
  assign done           = r_done;

`ifdef SHIFT_CTRL_CAPTURE_EN
  logic [N-1:0] r_rx_data;

  // Sample the MSB in the last low cycle, before the coming strobe moves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data <= '0;
    end else if (w_accept) begin
      r_rx_data <= '0;
    end else if ((r_state == SHIFT_LO) && w_tmr_expire) begin
      r_rx_data <= {r_rx_data[N-2:0], sr_serial_out};
    end
  end

  assign rx_data = r_rx_data;
`else
  logic w_unused_serial_out;
  assign w_unused_serial_out = sr_serial_out;
  assign rx_data             = '0;
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl with an attached clk-synchronous shift register; expected
// waveforms come from the latency formula: load in cycle 1, pulses at 1+k(p+1), done at 2+N(p+1).
`timescale 1ns/1ps
module tb_shift_ctrl;

  localparam int N     = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             fill_bit = 1'b0;
  logic [N-1:0]     tx_data = '0;
  logic [DIV_W-1:0] div = '0;
  logic             sr_serial_out;
  logic             start_ready, sr_load, sr_shift, sr_serial_in, busy, done;
  logic [N-1:0]     sr_parallel_in, rx_data;
  logic [N-1:0]     sr_q;

  int n_vec = 0;
  int n_err = 0;
  int load_edges = 0;
  int shift_edges = 0;

  always #5 clk = ~clk;

  shift_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .tx_data        (tx_data),
    .fill_bit       (fill_bit),
    .div            (div),
    .sr_serial_out  (sr_serial_out),
    .sr_load        (sr_load),
    .sr_shift       (sr_shift),
    .sr_serial_in   (sr_serial_in),
    .sr_parallel_in (sr_parallel_in),
    .busy           (busy),
    .done           (done),
    .rx_data        (rx_data)
  );

  // External shift register sharing the reset net
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sr_q <= '0;
    else if (sr_load)  sr_q <= sr_parallel_in;
    else if (sr_shift) sr_q <= {sr_q[N-2:0], sr_serial_in};
  end
  assign sr_serial_out = sr_q[N-1];

  always @(posedge sr_load)  load_edges++;
  always @(posedge sr_shift) shift_edges++;

  // One transfer: accept edge is cycle 0; every cycle 1..t_end compared against the timing formula.
  task automatic run_xfer(input logic [N-1:0] data, input logic [DIV_W-1:0] d,
                          input logic f, input bit hold, input bit noise);
    int p, t_end, s0;
    logic [5:0] exp_v, got_v;
    logic [N-1:0] exp_rx;
    p = (d == '0) ? 1 : int'(d);
    t_end = 2 + N * (p + 1);
`ifdef SHIFT_CTRL_CAPTURE_EN
    exp_rx = data;
`else
    exp_rx = '0;
`endif
    @(negedge clk);
    tx_data = data; div = d; fill_bit = f; start_valid = 1'b1;
    n_vec++;
    if (start_ready !== 1'b1) begin
      n_err++; $display("FAIL xfer_ready got=%b exp=1", start_ready);
    end
    s0 = shift_edges;
    @(posedge clk); #1;
    if (!hold) start_valid = 1'b0;
    for (int c = 1; c <= t_end; c++) begin
      @(negedge clk);
      exp_v = {(c == 1), (c > 1) && ((c - 1) % (p + 1) == 0), (c == t_end), 1'b1, f, 1'b0};
      got_v = {sr_load, sr_shift, done, busy, sr_serial_in, start_ready};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL xfer_strobes data=%h div=%0d c=%0d got{ld,sh,dn,bz,si,rdy}=%b exp=%b",
                 data, d, c, got_v, exp_v);
      end
      n_vec++;
      if (sr_parallel_in !== data) begin
        n_err++; $display("FAIL xfer_parallel_in c=%0d got=%h exp=%h", c, sr_parallel_in, data);
      end
      if (c == 1) begin
        n_vec++;
        if (rx_data !== '0) begin
          n_err++; $display("FAIL xfer_rx_clear got=%h exp=0", rx_data);
        end
      end
      if (c == t_end) begin
        n_vec++;
        if (rx_data !== exp_rx) begin
          n_err++; $display("FAIL xfer_rx_data got=%h exp=%h", rx_data, exp_rx);
        end
        n_vec++;
        if (sr_q !== {N{f}}) begin
          n_err++; $display("FAIL xfer_sr_out got=%h exp=%h", sr_q, {N{f}});
        end
        n_vec++;
        if (shift_edges - s0 != N) begin
          n_err++; $display("FAIL xfer_shift_count got=%0d exp=%0d", shift_edges - s0, N);
        end
      end
      if (noise && c < t_end) begin
        tx_data = N'($urandom); div = DIV_W'($urandom_range(0, 7)); fill_bit = 1'($urandom);
        if (!hold) start_valid = 1'($urandom);
      end
      if (c == t_end && !hold) start_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({sr_load, sr_shift, sr_serial_in, busy, done, start_ready} !== 6'b000001 ||
        sr_parallel_in !== '0 || rx_data !== '0) begin
      n_err++;
      $display("FAIL reset_async got{ld,sh,si,bz,dn,rdy}=%b pin=%h rx=%h exp=000001/0/0",
               {sr_load, sr_shift, sr_serial_in, busy, done, start_ready}, sr_parallel_in, rx_data);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    n_vec++;
    if (load_edges != 0 || shift_edges != 0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle load_edges=%0d shift_edges=%0d rdy=%b busy=%b exp=0/0/1/0",
               load_edges, shift_edges, start_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_xfer(8'hA5, 16'd1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_xfer(8'hA5, 16'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_xfer(8'h3C, 16'd3, 1'b1, 1'b1, 1'b1);
    run_xfer(8'h5A, 16'd2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int s0;
    @(negedge clk);
    tx_data = 8'h96; div = 16'd2; fill_bit = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if (sr_shift !== 1'b1) begin
      n_err++; $display("FAIL rmid_third_pulse got=%b exp=1", sr_shift);
    end
    s0 = shift_edges;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({sr_load, sr_shift, sr_serial_in, busy, done, start_ready} !== 6'b000001 ||
        sr_parallel_in !== '0) begin
      n_err++;
      $display("FAIL rmid_async got{ld,sh,si,bz,dn,rdy}=%b pin=%h exp=000001/0",
               {sr_load, sr_shift, sr_serial_in, busy, done, start_ready}, sr_parallel_in);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (shift_edges != s0 || start_ready !== 1'b1 || sr_shift !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_quiet extra_edges=%0d rdy=%b sh=%b exp=0/1/0",
               shift_edges - s0, start_ready, sr_shift);
    end
    run_xfer(8'h69, 16'd2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_capture();
    run_xfer(8'hC3, 16'd1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_xfer(N'($urandom), DIV_W'($urandom_range(0, 5)), 1'($urandom),
               (i < 7) ? 1'($urandom) : 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_capture();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
